// File: rtl/hazard_ctrl_pkg.sv
// Shared types and codes for the hazard controller: register width, writeback select
// codes, forwarding select codes, tracker entry and match/priority helpers.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_DRAM = 2'b01;
    localparam logic [1:0] WSEL_PC   = 2'b10;

    localparam logic [1:0] FWD_RD1   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      ld;
    } trk_t;

    // x0 is hardwired, so a read of it never depends on an in-flight producer.
    function automatic logic src_match(input trk_t e, input logic used, input reg_addr_t rs);
        return e.v && used && (rs != '0) && (e.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic m_ex, input logic m_mem, input logic m_wb);
        if (m_ex)       return FWD_EXMEM;
        else if (m_mem) return FWD_MEMWB;
        else if (m_wb)  return FWD_WB;
        else            return FWD_RD1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and the hazard controller.
// master = pipeline (drives decode fields), slave = hazard_ctrl (drives stall/flush/forward).
interface hazard_ctrl_if;

    logic                         id_valid;
    hazard_ctrl_pkg::reg_addr_t   id_rs1;
    logic                         id_rs1_used;
    hazard_ctrl_pkg::reg_addr_t   id_rs2;
    logic                         id_rs2_used;
    hazard_ctrl_pkg::reg_addr_t   id_rd;
    logic                         id_rf_we;
    logic [1:0]                   id_rf_wsel;
    logic                         ex_br_taken;

    logic                         stall_pc;
    logic                         stall_if_id;
    logic                         flush_if_id;
    logic                         flush_id_ex;
    logic [1:0]                   fwd_a_sel;
    logic [1:0]                   fwd_b_sel;
    logic [31:0]                  stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rf_we, id_rf_wsel, ex_br_taken,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               fwd_a_sel, fwd_b_sel, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rf_we, id_rf_wsel, ex_br_taken,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               fwd_a_sel, fwd_b_sel, stall_cycles
    );

endinterface

// File: rtl/hazard_track_stage.sv
// One in-flight destination tracker entry; 1-cycle latency, no backpressure (shifts every cycle).
// flush_i kills the valid bit of the entry being captured.
module hazard_track_stage
    import hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  trk_t entry_i,
    output trk_t entry_o
);

    trk_t entry_q;
    trk_t entry_d;

    always_comb begin
        entry_d   = entry_i;
        entry_d.v = entry_i.v && !flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush and EX operand forwarding selects from EX/MEM/WB tracker.
// Outputs are 0-cycle combinational from tracker + ID fields; no backpressure, tracker shifts every cycle.
// HAZARD_FORWARD_EN: defined = forward and stall only on load-use; undefined = stall until producer retires.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter logic [1:0] WSEL_LOAD    = WSEL_DRAM,
    parameter bit         RF_WB_BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    trk_t ex_d;
    trk_t ex_q;
    trk_t mem_q;
    trk_t wb_q;

    logic        stall_pc;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        hazard;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    logic m_ex_a, m_ex_b, m_mem_a, m_mem_b, m_wb_a, m_wb_b;

    always_comb begin
        ex_d.v  = hz.id_valid && hz.id_rf_we && (hz.id_rd != '0);
        ex_d.rd = hz.id_rd;
        ex_d.ld = (hz.id_rf_wsel == WSEL_LOAD);
    end

    hazard_track_stage u_ex  (.clk(clk), .rst_n(rst_n), .flush_i(flush_id_ex), .entry_i(ex_d),  .entry_o(ex_q));
    hazard_track_stage u_mem (.clk(clk), .rst_n(rst_n), .flush_i(1'b0),        .entry_i(ex_q),  .entry_o(mem_q));
    hazard_track_stage u_wb  (.clk(clk), .rst_n(rst_n), .flush_i(1'b0),        .entry_i(mem_q), .entry_o(wb_q));

    // The load flag of the retiring entry has no consumer.
    logic unused_wb_ld;
    assign unused_wb_ld = wb_q.ld;

    always_comb begin
        m_ex_a  = src_match(ex_q,  hz.id_rs1_used, hz.id_rs1);
        m_ex_b  = src_match(ex_q,  hz.id_rs2_used, hz.id_rs2);
        m_mem_a = src_match(mem_q, hz.id_rs1_used, hz.id_rs1);
        m_mem_b = src_match(mem_q, hz.id_rs2_used, hz.id_rs2);
        // With write-then-read regfile, a WB producer is already visible on rD1/rD2.
        m_wb_a  = !RF_WB_BYPASS && src_match(wb_q, hz.id_rs1_used, hz.id_rs1);
        m_wb_b  = !RF_WB_BYPASS && src_match(wb_q, hz.id_rs2_used, hz.id_rs2);
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
`ifdef HAZARD_FORWARD_EN
        hazard    = (m_ex_a || m_ex_b) && ex_q.ld;
        fwd_a_sel = fwd_pick(m_ex_a, m_mem_a, m_wb_a);
        fwd_b_sel = fwd_pick(m_ex_b, m_mem_b, m_wb_b);
`else
        hazard    = m_ex_a || m_ex_b || m_mem_a || m_mem_b || m_wb_a || m_wb_b;
        fwd_a_sel = FWD_RD1;
        fwd_b_sel = FWD_RD1;
`endif
        // A taken redirect squashes the stalled consumer anyway, so it overrides the stall.
        if (hz.ex_br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (hazard) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_pc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hz.stall_pc     = stall_pc;
    assign hz.stall_if_id  = stall_if_id;
    assign hz.flush_if_id  = flush_if_id;
    assign hz.flush_id_ex  = flush_id_ex;
    assign hz.fwd_a_sel    = fwd_a_sel;
    assign hz.fwd_b_sel    = fwd_b_sel;
    assign hz.stall_cycles = cnt_q;

endmodule
